// File: rtl/ascon_round_sequencer.sv
// ASCON-128 encryption round sequencer: one permutation round per cycle.
// Optional abort input when ASCON_ABORT_EN is defined.
module ascon_round_sequencer #(
    parameter int NB_BLOCKS = 4
) (
    input  logic       clock_i,
    input  logic       resetb_i,
`ifdef ASCON_ABORT_EN
    input  logic       abort_i,
`endif
    input  logic       start_i,
    input  logic       data_valid_i,
    output logic       data_ready_o,
    output logic       perm_en_o,
    output logic [3:0] round_o,
    output logic       sel_init_o,
    output logic       xor_data_begin_o,
    output logic       xor_key_begin_o,
    output logic       xor_key_end_o,
    output logic       xor_lsb_end_o,
    output logic       cipher_valid_o,
    output logic       tag_valid_o,
    output logic [1:0] block_o,
    output logic       busy_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_WAIT_AD,
        S_AD,
        S_WAIT_PT,
        S_PT,
        S_FINAL,
        S_DONE
    } state_t;

    localparam logic [3:0] RND_FIRST = 4'd0;
    localparam logic [3:0] RND_PB    = 4'd6;
    localparam logic [3:0] RND_LAST  = 4'd11;
    localparam logic [1:0] BLK_LAST  = 2'(NB_BLOCKS - 1);

    state_t     state_q, state_d;
    logic [3:0] rnd_q, rnd_d;
    logic [1:0] blk_q, blk_d;
    logic       last_rnd;
    logic       abort;

`ifdef ASCON_ABORT_EN
    assign abort = abort_i & (state_q != S_IDLE);
`else
    assign abort = 1'b0;
`endif

    assign last_rnd = (rnd_q == RND_LAST);
    assign busy_o   = (state_q != S_IDLE);
    assign block_o  = blk_q;

    // Next state and Mealy controls: an accepting cycle is already the first round.
    always_comb begin
        state_d          = state_q;
        rnd_d            = rnd_q;
        blk_d            = blk_q;
        data_ready_o     = 1'b0;
        perm_en_o        = 1'b0;
        round_o          = rnd_q;
        sel_init_o       = 1'b0;
        xor_data_begin_o = 1'b0;
        xor_key_begin_o  = 1'b0;
        xor_key_end_o    = 1'b0;
        xor_lsb_end_o    = 1'b0;
        cipher_valid_o   = 1'b0;
        tag_valid_o      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                round_o = RND_FIRST;
                if (start_i) begin
                    perm_en_o  = 1'b1;
                    sel_init_o = 1'b1;
                    blk_d      = 2'd0;
                    rnd_d      = RND_FIRST + 4'd1;
                    state_d    = S_INIT;
                end
            end
            S_INIT: begin
                perm_en_o = 1'b1;
                if (last_rnd) begin
                    xor_key_end_o = 1'b1;
                    state_d       = S_WAIT_AD;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end
            S_WAIT_AD: begin
                data_ready_o = 1'b1;
                if (data_valid_i) begin
                    perm_en_o        = 1'b1;
                    xor_data_begin_o = 1'b1;
                    round_o          = RND_PB;
                    rnd_d            = RND_PB + 4'd1;
                    state_d          = S_AD;
                end
            end
            S_AD: begin
                perm_en_o = 1'b1;
                if (last_rnd) begin
                    xor_lsb_end_o = 1'b1;
                    state_d       = S_WAIT_PT;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end
            S_WAIT_PT: begin
                data_ready_o = 1'b1;
                if (data_valid_i) begin
                    perm_en_o        = 1'b1;
                    xor_data_begin_o = 1'b1;
                    cipher_valid_o   = 1'b1;
                    if (blk_q == BLK_LAST) begin
                        xor_key_begin_o = 1'b1;
                        round_o         = RND_FIRST;
                        rnd_d           = RND_FIRST + 4'd1;
                        state_d         = S_FINAL;
                    end else begin
                        round_o = RND_PB;
                        rnd_d   = RND_PB + 4'd1;
                        state_d = S_PT;
                    end
                end
            end
            S_PT: begin
                perm_en_o = 1'b1;
                if (last_rnd) begin
                    blk_d   = blk_q + 2'd1;
                    state_d = S_WAIT_PT;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end
            S_FINAL: begin
                perm_en_o = 1'b1;
                if (last_rnd) begin
                    xor_key_end_o = 1'b1;
                    state_d       = S_DONE;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end
            S_DONE: begin
                tag_valid_o = 1'b1;
                round_o     = RND_FIRST;
                rnd_d       = RND_FIRST;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                rnd_d   = RND_FIRST;
            end
        endcase
        if (abort) begin
            data_ready_o     = 1'b0;
            perm_en_o        = 1'b0;
            round_o          = RND_FIRST;
            sel_init_o       = 1'b0;
            xor_data_begin_o = 1'b0;
            xor_key_begin_o  = 1'b0;
            xor_key_end_o    = 1'b0;
            xor_lsb_end_o    = 1'b0;
            cipher_valid_o   = 1'b0;
            tag_valid_o      = 1'b0;
            rnd_d            = RND_FIRST;
            blk_d            = 2'd0;
            state_d          = S_IDLE;
        end
    end

    // State, round counter and block index registers.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_q <= S_IDLE;
            rnd_q   <= RND_FIRST;
            blk_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            blk_q   <= blk_d;
        end
    end

endmodule

// File: tb/tb_ascon_round_sequencer.sv
// Bench for ascon_round_sequencer: per-cycle expectation list built
// from the message schedule (rounds per phase, waits, blocks).
module tb_ascon_round_sequencer;

    typedef struct packed {
        logic       perm;
        logic [3:0] rnd;
        logic       sel;
        logic       xdb;
        logic       xkb;
        logic       xke;
        logic       xle;
        logic       cv;
        logic       tag;
        logic       rdy;
        logic [1:0] blk;
        logic       busy;
        logic       st;
        logic       dv;
        logic [2:0] ph;
    } cyc_t;

    localparam logic [2:0] PH_IDLE = 3'd0;
    localparam logic [2:0] PH_INIT = 3'd1;
    localparam logic [2:0] PH_AD   = 3'd2;
    localparam logic [2:0] PH_PT   = 3'd3;
    localparam logic [2:0] PH_FIN  = 3'd4;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic abort = 1'b0;
    logic start4 = 1'b0, valid4 = 1'b0;
    logic start1 = 1'b0, valid1 = 1'b0;
    logic use1 = 1'b0;

    logic       rdy4, perm4, sel4, xdb4, xkb4, xke4, xle4, cv4, tag4, busy4;
    logic [3:0] rnd4;
    logic [1:0] blk4;
    logic       rdy1, perm1, sel1, xdb1, xkb1, xke1, xle1, cv1, tag1, busy1;
    logic [3:0] rnd1;
    logic [1:0] blk1;

    int checks = 0;
    int failures = 0;
    int cur_idx = 0;
    int tag_idx = -1;
    cyc_t q[$];
    cyc_t o;

    always #5 clk = ~clk;

    ascon_round_sequencer #(.NB_BLOCKS(4)) dut4 (
        .clock_i(clk), .resetb_i(rstn),
`ifdef ASCON_ABORT_EN
        .abort_i(abort),
`endif
        .start_i(start4), .data_valid_i(valid4),
        .data_ready_o(rdy4), .perm_en_o(perm4), .round_o(rnd4),
        .sel_init_o(sel4), .xor_data_begin_o(xdb4),
        .xor_key_begin_o(xkb4), .xor_key_end_o(xke4),
        .xor_lsb_end_o(xle4), .cipher_valid_o(cv4),
        .tag_valid_o(tag4), .block_o(blk4), .busy_o(busy4)
    );

    ascon_round_sequencer #(.NB_BLOCKS(1)) dut1 (
        .clock_i(clk), .resetb_i(rstn),
`ifdef ASCON_ABORT_EN
        .abort_i(1'b0),
`endif
        .start_i(start1), .data_valid_i(valid1),
        .data_ready_o(rdy1), .perm_en_o(perm1), .round_o(rnd1),
        .sel_init_o(sel1), .xor_data_begin_o(xdb1),
        .xor_key_begin_o(xkb1), .xor_key_end_o(xke1),
        .xor_lsb_end_o(xle1), .cipher_valid_o(cv1),
        .tag_valid_o(tag1), .block_o(blk1), .busy_o(busy1)
    );

    // Observed outputs of the DUT currently under test.
    always_comb begin
        o = '0;
        if (use1) begin
            o.perm = perm1; o.rnd = rnd1; o.sel = sel1; o.xdb = xdb1;
            o.xkb = xkb1; o.xke = xke1; o.xle = xle1; o.cv = cv1;
            o.tag = tag1; o.rdy = rdy1; o.blk = blk1; o.busy = busy1;
        end else begin
            o.perm = perm4; o.rnd = rnd4; o.sel = sel4; o.xdb = xdb4;
            o.xkb = xkb4; o.xke = xke4; o.xle = xle4; o.cv = cv4;
            o.tag = tag4; o.rdy = rdy4; o.blk = blk4; o.busy = busy4;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h",
                   tag, cur_idx, obs, exp);
        end
    endtask

    task automatic cmp(input cyc_t e);
        chk("perm_en", 32'(o.perm), 32'(e.perm));
        chk("round", 32'(o.rnd), 32'(e.rnd));
        chk("sel_init", 32'(o.sel), 32'(e.sel));
        chk("xor_data_begin", 32'(o.xdb), 32'(e.xdb));
        chk("xor_key_begin", 32'(o.xkb), 32'(e.xkb));
        chk("xor_key_end", 32'(o.xke), 32'(e.xke));
        chk("xor_lsb_end", 32'(o.xle), 32'(e.xle));
        chk("cipher_valid", 32'(o.cv), 32'(e.cv));
        chk("tag_valid", 32'(o.tag), 32'(e.tag));
        chk("data_ready", 32'(o.rdy), 32'(e.rdy));
        chk("block", 32'(o.blk), 32'(e.blk));
        chk("busy", 32'(o.busy), 32'(e.busy));
    endtask

    task automatic idle_rec(input logic [1:0] b, input logic busy);
        cyc_t r;
        r = '0;
        r.blk = b;
        r.busy = busy;
        r.dv = 1'($urandom);
        q.push_back(r);
    endtask

    // One phase of permutation rounds from lo up to 11.
    // kind: 0 nothing, 1 key XOR after last, 2 domain bit after last.
    task automatic run_rounds(input int lo, input logic [1:0] b,
                              input int kind, input logic [2:0] ph);
        cyc_t r;
        for (int k = lo; k <= 11; k++) begin
            r = '0;
            r.perm = 1'b1;
            r.rnd = 4'(k);
            r.blk = b;
            r.busy = 1'b1;
            r.st = 1'($urandom);
            r.dv = 1'($urandom);
            r.ph = ph;
            if (k == 11) begin
                r.xke = (kind == 1);
                r.xle = (kind == 2);
            end
            q.push_back(r);
        end
    endtask

    // Stall cycles in a wait state, then the accepting cycle skeleton.
    task automatic wait_blk(input logic [1:0] b, input int w,
                            output cyc_t acc);
        cyc_t r;
        for (int i = 0; i < w; i++) begin
            r = '0;
            r.rdy = 1'b1;
            r.rnd = 4'd11;
            r.blk = b;
            r.busy = 1'b1;
            r.st = 1'($urandom);
            q.push_back(r);
        end
        acc = '0;
        acc.rdy = 1'b1;
        acc.perm = 1'b1;
        acc.xdb = 1'b1;
        acc.blk = b;
        acc.busy = 1'b1;
        acc.dv = 1'b1;
        acc.st = 1'($urandom);
    endtask

    // Whole message: pa init, one AD block, nb PT blocks, pa final, tag.
    task automatic build(input int nb, input logic [1:0] pblk,
                         input int minw, input int maxw);
        cyc_t r;
        r = '0;
        r.perm = 1'b1;
        r.sel = 1'b1;
        r.blk = pblk;
        r.st = 1'b1;
        r.dv = 1'($urandom);
        q.push_back(r);
        run_rounds(1, 2'd0, 1, PH_INIT);
        wait_blk(2'd0, int'($urandom_range(maxw, minw)), r);
        r.rnd = 4'd6;
        q.push_back(r);
        run_rounds(7, 2'd0, 2, PH_AD);
        for (int b = 0; b < nb; b++) begin
            wait_blk(2'(b), int'($urandom_range(maxw, minw)), r);
            r.cv = 1'b1;
            if (b == nb - 1) begin
                r.xkb = 1'b1;
                r.rnd = 4'd0;
                q.push_back(r);
            end else begin
                r.rnd = 4'd6;
                q.push_back(r);
                run_rounds(7, 2'(b), 0, PH_PT);
            end
        end
        run_rounds(1, 2'(nb - 1), 1, PH_FIN);
        r = '0;
        r.tag = 1'b1;
        r.busy = 1'b1;
        r.blk = 2'(nb - 1);
        r.st = 1'($urandom);
        q.push_back(r);
        idle_rec(2'(nb - 1), 1'b0);
        idle_rec(2'(nb - 1), 1'b0);
    endtask

    // Replays q; stops before the record matching stop_ph/stop_rnd.
    task automatic play(input logic [2:0] stop_ph, input int stop_rnd);
        cyc_t e;
        tag_idx = -1;
        for (int i = 0; i < q.size(); i++) begin
            e = q[i];
            if (stop_ph != PH_IDLE && e.ph == stop_ph &&
                int'(e.rnd) == stop_rnd) begin
                start4 = 1'b0; valid4 = 1'b0;
                start1 = 1'b0; valid1 = 1'b0;
                q.delete();
                return;
            end
            cur_idx = i;
            start4 = use1 ? 1'b0 : e.st;
            valid4 = use1 ? 1'b0 : e.dv;
            start1 = use1 ? e.st : 1'b0;
            valid1 = use1 ? e.dv : 1'b0;
            @(negedge clk);
            cmp(e);
            if (o.tag === 1'b1 && tag_idx < 0) tag_idx = i;
            @(posedge clk);
            #1;
        end
        start4 = 1'b0; valid4 = 1'b0;
        start1 = 1'b0; valid1 = 1'b0;
        q.delete();
    endtask

    initial begin
        cyc_t z;
        // Reset state, then five quiet idle cycles.
        #2;
        @(negedge clk);
        z = '0;
        use1 = 1'b0;
        cmp(z);
        use1 = 1'b1;
        cmp(z);
        use1 = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int i = 0; i < 5; i++) idle_rec(2'd0, 1'b0);
        play(PH_IDLE, 0);

        // Zero-wait message: tag 48 cycles after start.
        build(4, 2'd0, 0, 0);
        play(PH_IDLE, 0);
        chk("tag_cycle", 32'(tag_idx), 32'd48);

        // Random backpressure, then a fixed 3-cycle stall everywhere.
        build(4, 2'd3, 0, 3);
        play(PH_IDLE, 0);
        build(4, 2'd3, 3, 3);
        play(PH_IDLE, 0);

        // Single-block configuration.
        use1 = 1'b1;
        build(1, 2'd0, 0, 0);
        play(PH_IDLE, 0);
        build(1, 2'd0, 0, 2);
        play(PH_IDLE, 0);
        use1 = 1'b0;

        // Reset during final round 5; next message starts clean.
        build(4, 2'd3, 0, 2);
        play(PH_FIN, 5);
        rstn = 1'b0;
        #1;
        z = '0;
        cmp(z);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        build(4, 2'd0, 0, 1);
        play(PH_IDLE, 0);

`ifdef ASCON_ABORT_EN
        // Abort in AD round 8, restart two cycles later.
        build(4, 2'd3, 0, 0);
        play(PH_AD, 8);
        abort = 1'b1;
        valid4 = 1'b1;
        start4 = 1'b1;
        @(negedge clk);
        z = '0;
        z.busy = 1'b1;
        cmp(z);
        @(posedge clk);
        #1;
        abort = 1'b0;
        valid4 = 1'b0;
        start4 = 1'b0;
        idle_rec(2'd0, 1'b0);
        idle_rec(2'd0, 1'b0);
        play(PH_IDLE, 0);
        build(4, 2'd0, 0, 0);
        play(PH_IDLE, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
